// File: rtl/divider_seq_restoring_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
// The master drives the request and the slave (the divider) returns results.
interface divider_seq_restoring_if #(
  parameter int bw = 8
);
  logic          start;
  logic [bw-1:0] A;
  logic [bw-1:0] B;
  logic          busy;
  logic          done;
  logic [bw-1:0] Q;
  logic [bw-1:0] R;
  logic          div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/divider_seq_restoring.sv
// Unsigned sequential restoring divider: Q = A / B, R = A % B.
// It produces one quotient bit per clock through a single shared subtractor.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands captured on an accepted start
// CALC  | bw restoring steps, one quotient bit per edge
// DONE  | one-cycle done pulse; Q/R/div_by_zero valid
module divider_seq_restoring #(
  parameter int bw = 8
) (
  input logic                      CLK,
  input logic                      RESET,
  divider_seq_restoring_if.slave   bus
);

  localparam int CW = (bw > 1) ? $clog2(bw) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [bw-1:0]   dividend;
  logic [bw-1:0]   divisor;
  logic [bw-1:0]   quot;
  logic [bw:0]     p_rem;
  logic [CW-1:0]   cnt;
  logic [bw-1:0]   q_reg;
  logic [bw-1:0]   r_reg;
  logic            dbz_reg;

  logic [bw:0]     rem_shift;
  logic [bw+1:0]   diff;
  logic            no_borrow;
  logic [bw:0]     p_nxt;
  logic [bw-1:0]   quot_nxt;
  logic            last_step;
  logic            accept;
  logic            div_zero_req;

  // P never exceeds the divisor after a step, so its top bit is always zero
  // and is kept only so the partial remainder has its full bw+1 width.
  logic [1:0]      unused_p_top;
  assign unused_p_top = {p_rem[bw], p_nxt[bw]};

  // One restoring step: trial subtract, keep the difference when it does not borrow.
  always_comb begin
    rem_shift = {p_rem[bw-1:0], dividend[bw-1]};
    diff      = {1'b0, rem_shift} - {2'b00, divisor};
    no_borrow = ~diff[bw+1];
    p_nxt     = no_borrow ? diff[bw:0] : rem_shift;
    quot_nxt  = {quot[bw-2:0], no_borrow};
  end

  assign last_step    = (cnt == '0);
  assign accept       = (state == IDLE) && bus.start;
  assign div_zero_req = (bus.B == '0);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = div_zero_req ? DONE : CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract steps and result registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dividend <= '0;
      divisor  <= '0;
      quot     <= '0;
      p_rem    <= '0;
      cnt      <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      dbz_reg  <= 1'b0;
    end else if (accept) begin
      if (div_zero_req) begin
        q_reg   <= '1;
        r_reg   <= bus.A;
        dbz_reg <= 1'b1;
      end else begin
        dividend <= bus.A;
        divisor  <= bus.B;
        quot     <= '0;
        p_rem    <= '0;
        cnt      <= CW'(bw - 1);
      end
    end else if (state == CALC) begin
      p_rem    <= p_nxt;
      quot     <= quot_nxt;
      dividend <= dividend << 1;
      cnt      <= cnt - 1'b1;
      if (last_step) begin
        q_reg   <= quot_nxt;
        r_reg   <= p_nxt[bw-1:0];
        dbz_reg <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.Q           = q_reg;
  assign bus.R           = r_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider_seq_restoring.sv
// Self-checking bench for divider_seq_restoring with directed and random operations.
module tb_divider_seq_restoring;
  localparam int BW   = 8;
  localparam int MAXV = (1 << BW) - 1;
  localparam int NOPS = 1200;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  divider_seq_restoring_if #(.bw(BW)) bus();

  divider_seq_restoring #(.bw(BW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic, with the all-ones / dividend convention for B == 0.
  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = MAXV; r = a; z = 1;
    end else begin
      q = a / b; r = a % b; z = 0;
    end
  endfunction

  task automatic run_op(input int a, input int b, input string tag);
    int q, r, z, n, exp_lat;
    ref_div(a, b, q, r, z);
    exp_lat = (b == 0) ? 1 : BW + 1;
    @(negedge clk);
    bus.A = a[BW-1:0]; bus.B = b[BW-1:0]; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = BW'($urandom); bus.B = BW'($urandom);
    n = 1;
    @(negedge clk);
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    check({tag, ".lat"}, n, exp_lat);
    check({tag, ".Q"}, 32'(bus.Q), q);
    check({tag, ".R"}, 32'(bus.R), r);
    check({tag, ".dbz"}, 32'(bus.div_by_zero), z);
    @(negedge clk);
    check({tag, ".idle"}, 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, ".holdQ"}, 32'(bus.Q), q);
  endtask

  int qa[NOPS];
  int qb[NOPS];

  initial begin
    int pulses, cap_q, cap_r, idx, last, cyc, q, r, z;

    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    #1;
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.Q", 32'(bus.Q), 0);
    check("rst.R", 32'(bus.R), 0);
    check("rst.dbz", 32'(bus.div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(100, 7, "t1");
    run_op(255, 1, "t2a");
    run_op(3, 200, "t2b");
    run_op(200, 200, "t2c");
    run_op(5, 0, "t3");
    run_op(0, 0, "t3z");
    run_op(0, 255, "t2d");

    // start during CALC must be ignored
    @(negedge clk);
    bus.A = 8'd100; bus.B = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.A = 8'd9; bus.B = 8'd3; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    pulses = 0; cap_q = -1; cap_r = -1;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++; cap_q = bus.Q; cap_r = bus.R;
      end
    end
    check("t4.pulses", pulses, 1);
    check("t4.Q", cap_q, 14);
    check("t4.R", cap_r, 2);

    // asynchronous reset mid-CALC
    @(negedge clk);
    bus.A = 8'd100; bus.B = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5.busy", 32'(bus.busy), 0);
    check("t5.done", 32'(bus.done), 0);
    check("t5.Q", 32'(bus.Q), 0);
    check("t5.R", 32'(bus.R), 0);
    check("t5.dbz", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("t5.nodone", pulses, 0);
    run_op(50, 6, "t5b");

    // back-to-back random sweep, next op presented on each done
    qa[0] = 255; qb[0] = 1;
    qa[1] = 255; qb[1] = 255;
    qa[2] = 254; qb[2] = 255;
    qa[3] = 0;   qb[3] = 1;
    qa[4] = 128; qb[4] = 3;
    qa[5] = 1;   qb[5] = 128;
    for (int i = 6; i < NOPS; i++) begin
      qa[i] = int'($urandom_range(0, MAXV));
      qb[i] = int'($urandom_range(1, MAXV));
    end
    @(negedge clk);
    bus.A = qa[0][BW-1:0]; bus.B = qb[0][BW-1:0]; bus.start = 1'b1;
    idx = 0; last = 0; cyc = 0;
    while (idx < NOPS && cyc < NOPS * 12 + 50) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.done) begin
        ref_div(qa[idx], qb[idx], q, r, z);
        check("t6.Q", 32'(bus.Q), q);
        check("t6.R", 32'(bus.R), r);
        check("t6.dbz", 32'(bus.div_by_zero), z);
        if (idx > 0) check("t6.spacing", cyc - last, BW + 2);
        last = cyc;
        idx++;
        if (idx < NOPS) begin
          bus.A = qa[idx][BW-1:0]; bus.B = qb[idx][BW-1:0];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("t6.count", idx, NOPS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
